// File: rtl/bp_pkg.sv
// Shared types for the branch predictor control slice.
// Metadata widths here must match the predictor's index widths.
package bp_pkg;

  localparam int BP_BHT_BITS = 3;
  localparam int BP_PHT_BITS = 7;

  localparam logic [31:0] BP_PC_STEP = 32'd8;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } predict_state_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bp_state_t;

  typedef struct packed {
    logic [BP_BHT_BITS-1:0] pc_hash;
    logic [BP_PHT_BITS-1:0] pht_index;
    logic                   pred_taken;
  } bp_meta_t;

endpackage

// File: rtl/bp_meta_fifo.sv
// In-flight branch metadata FIFO with synchronous clear.
// Push is ignored when full so a same-cycle pop never relieves full.
module bp_meta_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     clear,
  input  bp_meta_t din,
  output bp_meta_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  bp_meta_t      mem_q [DEPTH];
  bp_meta_t      mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Tracks in-flight predicted branches, trains the predictor, redirects on mispredict.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int PHT_INDEX_BITS = BP_PHT_BITS,
  parameter int BHT_INDEX_BITS = BP_BHT_BITS,
  parameter int DEPTH          = 4,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_valid,
  output logic                      f_ready,
  input  logic [BHT_INDEX_BITS-1:0] f_pc_hash,
  input  logic [PHT_INDEX_BITS-1:0] f_pht_index,
  input  logic                      f_pred_taken,
  input  logic                      e_resolve,
  input  logic                      e_taken,
  input  logic [31:0]               e_target,
  output logic                      branchE,
  output logic [BHT_INDEX_BITS-1:0] BHT_indexE,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexE,
  output logic                      actually_takenE,
  output logic                      predict_resultE,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
`ifdef BP_STATS_EN
  output logic [31:0]               stat_branches,
  output logic [31:0]               stat_mispredicts,
`endif
  output logic                      underflow_err
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  bp_state_t state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  logic branch_q, branch_d;
  logic [BHT_INDEX_BITS-1:0] bht_q, bht_d;
  logic [PHT_INDEX_BITS-1:0] pht_q, pht_d;
  logic taken_q, taken_d;
  logic redir_q, redir_d;
  logic [31:0] rpc_q, rpc_d;
  logic uf_q, uf_d;

  bp_meta_t fifo_din, fifo_head;
  logic fifo_full, fifo_empty;
  logic live, resolve_ok, mispredict;
  logic push, pop;

  assign live       = (state_q == RUN);
  assign resolve_ok = e_resolve && live && !fifo_empty;
  assign mispredict = resolve_ok &&
                      (fifo_head.pred_taken != e_taken);
  assign f_ready    = live && !fifo_full;
  assign push       = f_valid && f_ready && !mispredict;
  assign pop        = resolve_ok && !mispredict;

  assign fifo_din.pc_hash    = f_pc_hash;
  assign fifo_din.pht_index  = f_pht_index;
  assign fifo_din.pred_taken = f_pred_taken;

  bp_meta_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (1'b1)
      (state_q == RUN): begin
        if (mispredict) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end
      end
      default: begin
        if (fcnt_q == FLUSH_LAST) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    endcase
  end

  always_comb begin
    branch_d = resolve_ok;
    bht_d    = bht_q;
    pht_d    = pht_q;
    taken_d  = taken_q;
    redir_d  = mispredict;
    rpc_d    = rpc_q;
    uf_d     = uf_q | (e_resolve && live && fifo_empty);
    if (resolve_ok) begin
      bht_d   = fifo_head.pc_hash;
      pht_d   = fifo_head.pht_index;
      taken_d = e_taken;
    end
    if (mispredict) begin
      rpc_d = e_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      fcnt_q   <= '0;
      branch_q <= 1'b0;
      bht_q    <= '0;
      pht_q    <= '0;
      taken_q  <= 1'b0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      branch_q <= branch_d;
      bht_q    <= bht_d;
      pht_q    <= pht_d;
      taken_q  <= taken_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
      uf_q     <= uf_d;
    end
  end

  assign branchE         = branch_q;
  assign BHT_indexE      = bht_q;
  assign PHT_indexE      = pht_q;
  assign actually_takenE = taken_q;
  assign predict_resultE = taken_q;
  assign redirect_valid  = redir_q;
  assign redirect_pc     = rpc_q;
  assign underflow_err   = uf_q;

`ifdef BP_STATS_EN
  logic [31:0] sbr_q, sbr_d;
  logic [31:0] smp_q, smp_d;

  always_comb begin
    sbr_d = sbr_q;
    smp_d = smp_q;
    if (resolve_ok && (sbr_q != '1)) begin
      sbr_d = sbr_q + 32'd1;
    end
    if (mispredict && (smp_q != '1)) begin
      smp_d = smp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbr_q <= '0;
      smp_q <= '0;
    end else begin
      sbr_q <= sbr_d;
      smp_q <= smp_d;
    end
  end

  assign stat_branches    = sbr_q;
  assign stat_mispredicts = smp_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl (DEPTH=4, FLUSH_CYCLES=2).
// A reference queue model predicts updates, redirects, f_ready and underflow.
module tb_branch_predict_ctrl;

  localparam int DEPTH = 4;
  localparam int FLUSH = 2;

  typedef struct {
    logic [2:0] h;
    logic [6:0] ix;
    logic       p;
  } tmeta_t;

  typedef struct {
    logic [2:0]  h;
    logic [6:0]  ix;
    logic        tk;
    logic        mis;
    logic [31:0] tgt;
  } texp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic        f_ready;
  logic [2:0]  f_pc_hash;
  logic [6:0]  f_pht_index;
  logic        f_pred_taken;
  logic        e_resolve;
  logic        e_taken;
  logic [31:0] e_target;
  logic        branchE;
  logic [2:0]  BHT_indexE;
  logic [6:0]  PHT_indexE;
  logic        actually_takenE;
  logic        predict_resultE;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        underflow_err;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tmeta_t mq[$];
  texp_t  exq[$];
  int     flush_left = 0;
  bit     m_uf = 0;
  bit     mon_en = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .f_valid         (f_valid),
    .f_ready         (f_ready),
    .f_pc_hash       (f_pc_hash),
    .f_pht_index     (f_pht_index),
    .f_pred_taken    (f_pred_taken),
    .e_resolve       (e_resolve),
    .e_taken         (e_taken),
    .e_target        (e_target),
    .branchE         (branchE),
    .BHT_indexE      (BHT_indexE),
    .PHT_indexE      (PHT_indexE),
    .actually_takenE (actually_takenE),
    .predict_resultE (predict_resultE),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
`ifdef BP_STATS_EN
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .underflow_err   (underflow_err)
  );

  function automatic bit m_ready();
    return (flush_left == 0) && (mq.size() < DEPTH);
  endfunction

  // Drive one cycle of stimulus and advance the reference model.
  task automatic cycle(input bit fv, input logic [2:0] h,
                       input logic [6:0] ix, input bit pr,
                       input bit res, input bit tk,
                       input logic [31:0] tgt);
    bit     acc;
    bit     fl;
    bit     mis;
    tmeta_t hd;
    tmeta_t nw;
    texp_t  ex;
    acc = fv && m_ready();
    fl  = (flush_left > 0);
    f_valid = fv; f_pc_hash = h; f_pht_index = ix;
    f_pred_taken = pr; e_resolve = res;
    e_taken = tk; e_target = tgt;
    @(posedge clk);
    if (flush_left > 0) flush_left--;
    if (res && !fl) begin
      if (mq.size() == 0) begin
        m_uf = 1;
      end else begin
        hd  = mq[0];
        mis = (hd.p != tk);
        ex.h = hd.h; ex.ix = hd.ix; ex.tk = tk;
        ex.mis = mis; ex.tgt = tgt;
        exq.push_back(ex);
        if (mis) begin
          mq.delete();
          flush_left = FLUSH;
          acc = 0;
        end else begin
          void'(mq.pop_front());
        end
      end
    end
    if (acc) begin
      nw.h = h; nw.ix = ix; nw.p = pr;
      mq.push_back(nw);
    end
    #1;
    f_valid = 0;
    e_resolve = 0;
  endtask

  always @(negedge clk) begin : mon
    texp_t e;
    logic  eb;
    if (mon_en) begin
      eb = (exq.size() != 0);
      n_checks++;
      if (branchE !== eb) begin
        n_fail++;
        $display("FAIL branchE: got %b want %b", branchE, eb);
      end
      if (exq.size() != 0) begin
        e = exq.pop_front();
        n_checks++;
        if (BHT_indexE !== e.h || PHT_indexE !== e.ix) begin
          n_fail++;
          $display("FAIL upd_idx: got %h/%h want %h/%h",
                   BHT_indexE, PHT_indexE, e.h, e.ix);
        end
        n_checks++;
        if (predict_resultE !== e.tk || actually_takenE !== e.tk) begin
          n_fail++;
          $display("FAIL upd_dir: got %b/%b want %b",
                   predict_resultE, actually_takenE, e.tk);
        end
        n_checks++;
        if (redirect_valid !== e.mis) begin
          n_fail++;
          $display("FAIL redirect_valid: got %b want %b",
                   redirect_valid, e.mis);
        end
        if (e.mis) begin
          n_checks++;
          if (redirect_pc !== e.tgt) begin
            n_fail++;
            $display("FAIL redirect_pc: got %h want %h",
                     redirect_pc, e.tgt);
          end
        end
      end else begin
        n_checks++;
        if (redirect_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL redirect_idle: got %b want 0", redirect_valid);
        end
      end
      n_checks++;
      if (f_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL f_ready: got %b want %b", f_ready, m_ready());
      end
      n_checks++;
      if (underflow_err !== m_uf) begin
        n_fail++;
        $display("FAIL underflow_err: got %b want %b", underflow_err, m_uf);
      end
    end
  end

  task automatic test_reset();
    rst = 0;
    f_valid = 0; f_pc_hash = 0; f_pht_index = 0; f_pred_taken = 0;
    e_resolve = 0; e_taken = 0; e_target = 0;
    #3;
    n_checks++;
    if (f_ready !== 1'b1 || branchE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy_br: got %b/%b want 1/0", f_ready, branchE);
    end
    n_checks++;
    if (redirect_valid !== 1'b0 || underflow_err !== 1'b0 ||
        redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %b/%b/%h want 0/0/0",
               redirect_valid, underflow_err, redirect_pc);
    end
    @(negedge clk);
    rst = 1;
    #1;
    mon_en = 1;
  endtask

  task automatic test_fill();
    cycle(1, 3'd1, 7'h11, 1, 0, 0, 0);
    cycle(1, 3'd2, 7'h22, 0, 0, 0, 0);
    cycle(1, 3'd4, 7'h44, 1, 0, 0, 0);
    cycle(1, 3'd5, 7'h55, 0, 0, 0, 0);
    n_checks++;
    if (f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got %b want 0", f_ready);
    end
    cycle(1, 3'd7, 7'h7F, 1, 0, 0, 0);
    cycle(1, 3'd6, 7'h66, 0, 1, mq[0].p, 0);
    n_checks++;
    if (f_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_pop_rdy: got %b want 1", f_ready);
    end
    cycle(1, 3'd3, 7'h33, 1, 1, mq[0].p, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, mq[0].p, 0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_correct();
    cycle(1, 3'd3, 7'h15, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 32'h0);
    n_checks++;
    if (branchE !== 1'b1 || BHT_indexE !== 3'd3 ||
        PHT_indexE !== 7'h15 || predict_resultE !== 1'b1 ||
        redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL correct: got %b %h %h %b %b want 1 3 15 1 0",
               branchE, BHT_indexE, PHT_indexE,
               predict_resultE, redirect_valid);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_mispredict();
    cycle(1, 3'd6, 7'h3C, 0, 0, 0, 0);
    cycle(1, 3'd2, 7'h01, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 32'hBFC0_0100);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0100 ||
        f_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mispredict: got %b %h %b want 1 bfc00100 0",
               redirect_valid, redirect_pc, f_ready);
    end
    cycle(1, 3'd1, 7'h09, 1, 1, 1, 32'h1234);
    n_checks++;
    if (f_ready !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush1: got %b/%b want 0/0", f_ready, redirect_valid);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (f_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_end: got %b want 1", f_ready);
    end
  endtask

  task automatic test_underflow();
    cycle(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (underflow_err !== 1'b1 || branchE !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow: got %b/%b want 1/0", underflow_err, branchE);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (underflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_sticky: got %b want 1", underflow_err);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 3'd5, 7'h2A, 0, 0, 0, 0);
    mon_en = 0;
    e_resolve = 1; e_taken = 1; e_target = 32'h0000_4000;
    @(posedge clk);
    #1;
    e_resolve = 0;
    n_checks++;
    if (branchE !== 1'b1 || redirect_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: got %b/%b want 1/1", branchE, redirect_valid);
    end
    rst = 0;
    #1;
    n_checks++;
    if (branchE !== 1'b0 || redirect_valid !== 1'b0 ||
        f_ready !== 1'b1 || underflow_err !== 1'b0 ||
        PHT_indexE !== 7'h0) begin
      n_fail++;
      $display("FAIL mid_rst: got %b %b %b %b %h want 0 0 1 0 0",
               branchE, redirect_valid, f_ready,
               underflow_err, PHT_indexE);
    end
    mq.delete();
    exq.delete();
    flush_left = 0;
    m_uf = 0;
    @(negedge clk);
    rst = 1;
    #1;
    mon_en = 1;
  endtask

  task automatic test_mis_push();
    cycle(1, 3'd7, 7'h70, 1, 0, 0, 0);
    cycle(1, 3'd4, 7'h40, 0, 1, 0, 32'h8000_0010);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (underflow_err !== 1'b0 || f_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_flush: got %b/%b want 0/1", underflow_err, f_ready);
    end
    cycle(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (underflow_err !== 1'b1 || branchE !== 1'b0) begin
      n_fail++;
      $display("FAIL discard: got %b/%b want 1/0", underflow_err, branchE);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_correct();
    test_mispredict();
    test_underflow();
    test_reset_mid();
    test_mis_push();
    cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
